// File: rtl/half_adder_pkg.sv
// Shared types and constants for the half-adder leaf cell and its lane array.
package half_adder_pkg;

  localparam int HA_DEFAULT_WIDTH = 1;

  typedef struct packed {
    logic sum;
    logic carry;
  } ha_res_t;

  function automatic ha_res_t ha_eval(input logic a, input logic b);
    ha_res_t r;
    r.sum   = a ^ b;
    r.carry = a & b;
    return r;
  endfunction

endpackage

// File: rtl/half_adder_bit.sv
// Single-lane half-adder cell. The struct keeps the sum/carry pair together.
module ha_bit
  import half_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  ha_res_t res;

  always_comb res = ha_eval(a, b);

  assign sum   = res.sum;
  assign carry = res.carry;

endmodule

// File: rtl/half_adder.sv
// Lane-parallel half adder with a combinational result and an optional
// En-gated registered copy carrying a valid flag.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH   = HA_DEFAULT_WIDTH,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             En,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Carry,
  output logic [WIDTH-1:0] Sum_r,
  output logic [WIDTH-1:0] Carry_r,
  output logic             Valid_r
);

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;

  // Lanes are fully independent; no carry ever crosses a lane boundary.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_bit u_bit (
      .a     (A[i]),
      .b     (B[i]),
      .sum   (sum_w[i]),
      .carry (carry_w[i])
    );
  end

  assign Sum   = sum_w;
  assign Carry = carry_w;

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_d,   sum_q;
    logic [WIDTH-1:0] carry_d, carry_q;
    logic             valid_d, valid_q;

    always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      valid_d = valid_q;
      if (En) begin
        sum_d   = sum_w;
        carry_d = carry_w;
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= '0;
        valid_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end
    end

    assign Sum_r   = sum_q;
    assign Carry_r = carry_q;
    assign Valid_r = valid_q;
  end else begin : g_noreg
    assign Sum_r   = '0;
    assign Carry_r = '0;
    assign Valid_r = 1'b0;
  end

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: scalar, 8-lane and 4-lane (unregistered) instances.
module tb_half_adder;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;

  logic       a1 = 1'b0, b1 = 1'b0;
  logic       s1, c1, sr1, cr1, vr1;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] s8, c8, sr8, cr8;
  logic       vr8;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] s4, c4, sr4, cr4;
  logic       vr4;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 if (clk_run) clk = ~clk;

  half_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .En(en),
    .Sum(s1), .Carry(c1), .Sum_r(sr1), .Carry_r(cr1), .Valid_r(vr1));

  half_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .En(en),
    .Sum(s8), .Carry(c8), .Sum_r(sr8), .Carry_r(cr8), .Valid_r(vr8));

  half_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .En(en),
    .Sum(s4), .Carry(c4), .Sum_r(sr4), .Carry_r(cr4), .Valid_r(vr4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      chk("sb_underflow", exp_q.size(), 1);
    end else begin
      chk(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] ab_tbl [4];
    logic [1:0] cs_tbl [4];
    logic [3:0] ec, es;
    logic [1:0] t;
    ab_tbl = '{2'b00, 2'b01, 2'b10, 2'b11};
    cs_tbl = '{2'b00, 2'b01, 2'b01, 2'b10};

    // reset state, no clock running
    #1;
    sb_push("rst_reg1", 32'h0);
    sb_pop({vr1, cr1, sr1});
    sb_push("noreg_tie", 32'h0);
    sb_pop({vr4, cr4, sr4});

    // scalar truth table, {carry,sum}
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = ab_tbl[i];
      sb_push($sformatf("tt_%0d", i), {30'd0, cs_tbl[i]});
      #5;
      sb_pop({c1, s1});
      #5;
    end

    // 8-lane patterns, {carry,sum}
    a8 = 8'hF0; b8 = 8'hCC;
    sb_push("w8_f0cc", 32'hC03C);
    #1; sb_pop({c8, s8});
    a8 = 8'hFF; b8 = 8'hFF;
    sb_push("w8_ffff", 32'hFF00);
    #1; sb_pop({c8, s8});

    // registered capture, {valid,carry,sum}
    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b0; a1 = 1'b1; b1 = 1'b1; en = 1'b1;
    sb_push("reg_cap", 32'h6);
    @(posedge clk); #1;
    sb_pop({vr1, cr1, sr1});

    // hold with En low
    en = 1'b0; a1 = 1'b1; b1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sb_push($sformatf("hold_%0d", k), 32'h6);
      @(posedge clk); #1;
      sb_pop({vr1, cr1, sr1});
    end
    sb_push("hold_comb", 32'h1);
    sb_pop({c1, s1});

    // async reset between edges
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    sb_push("async_rst", 32'h0);
    sb_pop({vr1, cr1, sr1});
    sb_push("async_comb", 32'h1);
    sb_pop({c1, s1});
    en = 1'b1;
    sb_push("rst_held", 32'h0);
    sb_push("noreg_en", 32'h0);
    @(posedge clk); #1;
    sb_pop({vr1, cr1, sr1});
    sb_pop({vr4, cr4, sr4});

    // after release, no capture until En
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    sb_push("post_rst_idle", 32'h0);
    repeat (2) @(posedge clk);
    #1; sb_pop({vr1, cr1, sr1});
    a1 = 1'b0; b1 = 1'b1; en = 1'b1;
    sb_push("post_rst_cap", 32'h5);
    @(posedge clk); #1;
    sb_pop({vr1, cr1, sr1});
    en = 1'b0;

    // exhaustive 4-lane against per-lane integer add
    for (int p = 0; p < 256; p++) begin
      {a4, b4} = p[7:0];
      for (int i = 0; i < 4; i++) begin
        t = {1'b0, a4[i]} + {1'b0, b4[i]};
        ec[i] = t[1];
        es[i] = t[0];
      end
      sb_push($sformatf("w4_%0h", p), {24'd0, ec, es});
      #1;
      sb_pop({24'd0, c4, s4});
    end

    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
